// File: rtl/code_entry_ctrl.sv
// Keypad code entry: collects up to four BCD digits, submits on ENTER,
// and drives the blank/code/Err display mode with idle and error-hold timers.
module code_entry_ctrl #(
  parameter int IDLE_CYCLES = 1000,
  parameter int ERR_CYCLES  = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        err_req,
  output logic [15:0] entered_code,
  output logic [2:0]  display_mode,
  output logic [2:0]  digit_count,
  output logic        code_valid
);
  localparam int MAXC = (IDLE_CYCLES > ERR_CYCLES) ? IDLE_CYCLES : ERR_CYCLES;
  localparam int TW   = $clog2(MAXC);

  localparam logic [1:0] S_BLANK  = 2'd0;
  localparam logic [1:0] S_ENTRY  = 2'd1;
  localparam logic [1:0] S_SUBMIT = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  localparam logic [2:0] M_BLANK = 3'b100;
  localparam logic [2:0] M_CODE  = 3'b010;
  localparam logic [2:0] M_ERR   = 3'b001;

  // Idle exits one edge early so BLANK shows IDLE_CYCLES-1 edges after the last key.
  localparam logic [TW-1:0] IDLE_TC = TW'(IDLE_CYCLES - 2);
  localparam logic [TW-1:0] ERR_TC  = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0] T_SAT   = {TW{1'b1}};

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          is_digit, is_clear, is_enter;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_clear = key_valid && (key_code == 4'hA);
  assign is_enter = key_valid && (key_code == 4'hB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_BLANK;
      timer        <= '0;
      entered_code <= 16'h0000;
      digit_count  <= 3'd0;
      display_mode <= M_BLANK;
      code_valid   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (err_req) begin
        state        <= S_ERROR;
        display_mode <= M_ERR;
        timer        <= '0;
        entered_code <= 16'h0000;
        digit_count  <= 3'd0;
      end else begin
        case (state)
          S_BLANK: begin
            if (is_digit) begin
              entered_code <= {12'h000, key_code};
              digit_count  <= 3'd1;
              state        <= S_ENTRY;
              display_mode <= M_CODE;
              timer        <= '0;
            end
          end
          S_ENTRY: begin
            if (is_digit) begin
              timer <= '0;
              if (digit_count < 3'd4) begin
                entered_code <= {entered_code[11:0], key_code};
                digit_count  <= digit_count + 3'd1;
              end
            end else if (is_clear) begin
              entered_code <= 16'h0000;
              digit_count  <= 3'd0;
              state        <= S_BLANK;
              display_mode <= M_BLANK;
            end else if (is_enter) begin
              timer <= '0;
              if (digit_count == 3'd4) begin
                code_valid <= 1'b1;
                state      <= S_SUBMIT;
              end else begin
                // Short code: keep the partial digits, they are cleared when the hold ends.
                state        <= S_ERROR;
                display_mode <= M_ERR;
              end
            end else if (timer == IDLE_TC) begin
              entered_code <= 16'h0000;
              digit_count  <= 3'd0;
              state        <= S_BLANK;
              display_mode <= M_BLANK;
            end else if (timer != T_SAT) begin
              timer <= timer + 1'b1;
            end
          end
          S_SUBMIT: begin
            entered_code <= 16'h0000;
            digit_count  <= 3'd0;
            state        <= S_BLANK;
            display_mode <= M_BLANK;
          end
          default: begin
            if (timer == ERR_TC) begin
              timer        <= '0;
              entered_code <= 16'h0000;
              digit_count  <= 3'd0;
              state        <= S_BLANK;
              display_mode <= M_BLANK;
            end else if (timer != T_SAT) begin
              timer <= timer + 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_code_entry_ctrl.sv
// Bench for code_entry_ctrl: directed scenarios with literal expectations plus
// random key traffic checked every cycle against a deadline-based model.
module tb_code_entry_ctrl;
  localparam int IDLE = 20;
  localparam int ERR  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        err_req;
  logic [15:0] entered_code;
  logic [2:0]  display_mode;
  logic [2:0]  digit_count;
  logic        code_valid;

  int total = 0;
  int bad   = 0;

  code_entry_ctrl #(.IDLE_CYCLES(IDLE), .ERR_CYCLES(ERR)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .err_req(err_req), .entered_code(entered_code), .display_mode(display_mode),
    .digit_count(digit_count), .code_valid(code_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Model: phase 0 blank, 1 entry, 2 submit, 3 error; timeouts as absolute edge numbers.
  int     ph = 0;
  int     q[$];
  longint cyc = 0;
  longint idle_dead = 0;
  longint err_dead  = 0;
  bit     m_cv = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; q.delete(); m_cv = 0; cyc = 0;
    end else begin
      cyc++;
      m_cv = 0;
      if (err_req) begin
        ph = 3; err_dead = cyc + ERR; q.delete();
      end else begin
        case (ph)
          0: if (key_valid && key_code <= 9) begin
               q.delete(); q.push_back(int'(key_code)); ph = 1; idle_dead = cyc + IDLE - 1;
             end
          1: begin
               if (key_valid && key_code <= 11) idle_dead = cyc + IDLE - 1;
               if (key_valid && key_code <= 9) begin
                 if (q.size() < 4) q.push_back(int'(key_code));
               end else if (key_valid && key_code == 4'hA) begin
                 q.delete(); ph = 0;
               end else if (key_valid && key_code == 4'hB) begin
                 if (q.size() == 4) begin ph = 2; m_cv = 1; end
                 else begin ph = 3; err_dead = cyc + ERR; end
               end else if (cyc == idle_dead) begin
                 q.delete(); ph = 0;
               end
             end
          2: begin q.delete(); ph = 0; end
          default: if (cyc == err_dead) begin q.delete(); ph = 0; end
        endcase
      end
    end
  end

  function automatic logic [15:0] m_code();
    logic [15:0] v = 16'h0;
    foreach (q[i]) v = {v[11:0], q[i][3:0]};
    return v;
  endfunction

  function automatic logic [2:0] m_mode();
    return (ph == 0) ? 3'b100 : (ph == 3) ? 3'b001 : 3'b010;
  endfunction

  always @(negedge clk) begin
    chk("code", {16'h0, entered_code}, {16'h0, m_code()});
    chk("mode", {29'h0, display_mode}, {29'h0, m_mode()});
    chk("count", {29'h0, digit_count}, q.size());
    chk("valid", {31'h0, code_valid}, {31'h0, m_cv});
  end

  task automatic tick(input logic kv, input logic [3:0] kc, input logic er);
    @(negedge clk);
    key_valid = kv; key_code = kc; err_req = er;
  endtask

  task automatic idle();
    tick(1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    int n, ncv, r, kp;
    logic [3:0] k;
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; err_req = 1'b0;
    @(negedge clk); #2;
    chk("rst_code", {16'h0, entered_code}, 32'h0);
    chk("rst_mode", {29'h0, display_mode}, 32'h4);
    chk("rst_count", {29'h0, digit_count}, 32'h0);
    chk("rst_valid", {31'h0, code_valid}, 32'h0);
    @(negedge clk); #2 rst_n = 1'b1;

    // 9,0,7,0,ENTER
    tick(1, 4'h9, 0); tick(1, 4'h0, 0); tick(1, 4'h7, 0); tick(1, 4'h0, 0); tick(1, 4'hB, 0);
    idle();
    chk("sub_code", {16'h0, entered_code}, 32'h9070);
    chk("model_sub_code", {16'h0, m_code()}, 32'h9070);
    chk("sub_count", {29'h0, digit_count}, 32'd4);
    chk("sub_valid", {31'h0, code_valid}, 32'h1);
    idle();
    chk("post_valid", {31'h0, code_valid}, 32'h0);
    chk("post_mode", {29'h0, display_mode}, 32'h4);
    chk("post_code", {16'h0, entered_code}, 32'h0);

    // 1,2,3,4,5 then CLEAR
    tick(1, 4'h1, 0); tick(1, 4'h2, 0); tick(1, 4'h3, 0); tick(1, 4'h4, 0); tick(1, 4'h5, 0);
    idle();
    chk("five_code", {16'h0, entered_code}, 32'h1234);
    chk("five_count", {29'h0, digit_count}, 32'd4);
    tick(1, 4'hA, 0); idle();
    chk("clr_code", {16'h0, entered_code}, 32'h0);
    chk("clr_mode", {29'h0, display_mode}, 32'h4);

    // short code 4,2,ENTER: Err held exactly ERR cycles, no pulse
    tick(1, 4'h4, 0); tick(1, 4'h2, 0); tick(1, 4'hB, 0);
    n = 0; ncv = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (display_mode == 3'b001) n++;
      if (code_valid) ncv++;
    end
    chk("short_err_len", n, ERR);
    chk("short_no_valid", ncv, 0);
    chk("model_short_mode", {29'h0, m_mode()}, 32'h4);

    // idle timeout: key 7, silence 19 cycles; then restart with a second key
    tick(1, 4'h7, 0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      idle();
      if (display_mode == 3'b010 && entered_code == 16'h0007) n++;
    end
    chk("idle_len", n, IDLE - 1);
    chk("idle_code", {16'h0, entered_code}, 32'h0);
    tick(1, 4'h7, 0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 14) tick(1, 4'h3, 0); else idle();
      if (i == 16) chk("restart_code", {16'h0, entered_code}, 32'h0073);
      if (display_mode == 3'b010) n++;
    end
    chk("restart_len", n, 34);

    // err_req with a digit in ENTRY, then re-request mid-hold
    tick(1, 4'h5, 0); tick(1, 4'h6, 1); idle();
    chk("errk_mode", {29'h0, display_mode}, 32'h1);
    chk("errk_count", {29'h0, digit_count}, 32'h0);
    idle(); idle();
    tick(0, 4'h0, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (display_mode == 3'b001) n++;
    end
    chk("rehold_len", n, ERR);

    // async reset during SUBMIT
    tick(1, 4'h1, 0); tick(1, 4'h2, 0); tick(1, 4'h3, 0); tick(1, 4'h4, 0); tick(1, 4'hB, 0);
    idle();
    chk("pre_rst_valid", {31'h0, code_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, code_valid}, 32'h0);
    chk("arst_mode", {29'h0, display_mode}, 32'h4);
    chk("arst_code", {16'h0, entered_code}, 32'h0);
    chk("arst_count", {29'h0, digit_count}, 32'h0);
    @(negedge clk); #2 rst_n = 1'b1;

    // ignored codes in BLANK and ENTRY
    tick(1, 4'hC, 0); tick(1, 4'hD, 0); tick(1, 4'hE, 0); tick(1, 4'hF, 0); idle();
    chk("ign_blank_mode", {29'h0, display_mode}, 32'h4);
    chk("ign_blank_code", {16'h0, entered_code}, 32'h0);
    tick(1, 4'h3, 0); tick(1, 4'hE, 0); tick(1, 4'hF, 0); idle();
    chk("ign_entry_code", {16'h0, entered_code}, 32'h0003);
    chk("ign_entry_count", {29'h0, digit_count}, 32'd1);
    tick(1, 4'hA, 0);

    // random traffic; density varies so idle timeouts also occur
    for (int i = 0; i < 4000; i++) begin
      kp = ((i / 300) % 3 == 0) ? 2 : ((i / 300) % 3 == 1) ? 6 : 40;
      r  = int'($urandom_range(0, 19));
      k  = (r < 12) ? 4'($urandom_range(0, 9)) : (r < 15) ? 4'hB : (r < 17) ? 4'hA
         : 4'($urandom_range(12, 15));
      tick(($urandom_range(0, kp - 1) == 0), k, ($urandom_range(0, 79) == 0));
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
      end
    end
    idle();
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
